dcache_load_port: RTL and testbench
===================================

Name: dcache_load_port

Overview:
- Read side of the data cache: the stage directly downstream of the load reservation station's address output.
- Accepts one load address at a time and returns the 32-bit word with a one-cycle success pulse.
- Direct-mapped; refills a missed block from main memory with a word-serial handshake.
- Snoops store writes (write-through path) so cached lines never go stale.

Parameters:
- NUMBER_OF_BLOCKS_IN_CACHE_LOG, 2, log2 of line count (4 lines).
- BLOCK_SIZE_LOG, 4, log2 of line size in bytes (16 B = 4 words).
- ADDR_WIDTH, 32, byte address width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- readRequest  in  1  load request strobe; sampled only while readReady=1.
- readPtr  in  ADDR_WIDTH  byte address; bits [1:0] are ignored (word aligned).
- readReady  out  1  high in IDLE.
- readValue  out  32  returned word; valid only while readSuccess=1.
- readSuccess  out  1  one-cycle pulse.
- busy  out  2^NUMBER_OF_BLOCKS_IN_CACHE_LOG  bit i high while line i is being refilled.
- mem_req  out  1  memory word-read request.
- mem_addr  out  ADDR_WIDTH  word address for the memory read.
- mem_ack  in  1  memory returns mem_data this cycle.
- mem_data  in  32  memory read data.
- write_en  in  1  store snoop strobe.
- write_addr  in  ADDR_WIDTH  store byte address.
- write_data  in  32  store word.

Behaviour:
- Address split: word = addr[BLOCK_SIZE_LOG-1:2]; index = next NUMBER_OF_BLOCKS_IN_CACHE_LOG bits; tag = remaining upper bits.
- Storage: per line, a valid bit, a tag and 4 words.
- Reset (async, reset=0):
  - all valid bits cleared; state=IDLE;
  - readSuccess=0, readValue=0, mem_req=0, mem_addr=0, busy=0, readReady deasserted while reset is low.
- States: IDLE, LOOKUP, REFILL, RESPOND.
- IDLE: on readRequest=1, capture readPtr and go to LOOKUP.
- LOOKUP (one cycle):
  - hit (valid && tag match) -> RESPOND;
  - miss -> clear the line's valid bit, write the new tag, clear the 4-bit snoop mask, set refill count=0, go to REFILL.
- REFILL:
  - mem_req=1, mem_addr = {tag, index, count, 2'b00}.
  - On mem_ack: write mem_data into word[count] unless snoop-mask bit count is set; count++.
  - After the 4th ack: set valid, go to RESPOND.
  - mem_req deasserts in the cycle after the final ack.
  - busy[index]=1 for the whole REFILL state.
- RESPOND: readSuccess=1 for one cycle, readValue = line word; then IDLE.
- Latency:
  - hit: request edge at cycle 0, readSuccess high in cycle 2;
  - miss: readSuccess high 2 cycles after the final mem_ack edge.
- Back-to-back: the next request can be accepted in the cycle after RESPOND.
- Snoop writes, any state:
  - write_en=1 with valid && tag match: update that word.
  - If the write targets the line and tag currently in REFILL: update the word and set its snoop-mask bit; later refill data for that word is discarded. The merged value is what is returned.
  - Writes to non-resident lines are ignored (no allocate).
- Snoop and response in the same cycle: snoop has priority; readValue reflects the snooped data in that same cycle, because readValue is combinational from the array in RESPOND.
- Snoop and the final refill ack to the same word in the same cycle: snoop wins.
- Conflict eviction: a miss to an index holding a different tag overwrites the line; there is no writeback (stores are write-through).
- readRequest outside IDLE: ignored, not queued.
- Reset mid-REFILL:
  - mem_req drops immediately;
  - no readSuccess is produced;
  - a late mem_ack after reset release is ignored (IDLE ignores mem_ack).

Optional Feature:
- Macro: DCACHE_LOAD_STATS_EN.
- Defined: adds outputs hitCount[31:0] and missCount[31:0]. Each increments at LOOKUP resolution, wraps modulo 2^32, and clears on reset.
- Undefined: no ports, no counter logic.

Decomposition:
- Shared package/include: NUMBER_OF_BLOCKS_IN_CACHE(_LOG), BLOCK_SIZE_LOG, WORDS_PER_BLOCK, the state encoding constants, and the tag/index/word field width constants.
- One sub-module: dcache_line_array (valid/tag/data storage with read port, refill write port and snoop write port, snoop priority inside).
- The FSM stays in the top module.

Test Plan:
- Cold miss: readPtr=0x100, mem returns 0xA0..0xA3 with ack every cycle -> readSuccess with readValue=0xA0. mem_addr sequence is 0x100, 0x104, 0x108, 0x10C; busy[0] is high during the refill.
- Hit: then readPtr=0x108 -> readSuccess in cycle 2 with 0xA2; mem_req stays 0.
- Conflict: readPtr=0x140 (same index 0, new tag) -> refill. A subsequent read of 0x100 misses again; missCount=3 with stats enabled.
- Snoop hit: write 0x104 <= 0xDEAD, then read 0x104 -> 0xDEAD with no memory traffic.
- Merge during refill: miss on 0x200 with mem_ack stalled 3 cycles per word, plus write 0x208 <= 0x1234 mid-refill. Read returns 0x1234; word 0x208 is not overwritten by mem_data.
- Reset mid-refill: assert reset after the 2nd ack -> mem_req=0 at once, no readSuccess, line invalid. A re-read after release misses.

Source files
------------

// File: rtl/dcache_load_port_pkg.sv
// Shared geometry, address field layout and FSM encoding for the load-side data cache.
// Build option DCACHE_LOAD_STATS_EN (see dcache_load_port) adds hit/miss counters.
package dcache_load_port_pkg;

    localparam int ADDR_WIDTH                    = 32;
    localparam int DATA_W                        = 32;
    localparam int NUMBER_OF_BLOCKS_IN_CACHE_LOG = 2;
    localparam int NUMBER_OF_BLOCKS_IN_CACHE     = 1 << NUMBER_OF_BLOCKS_IN_CACHE_LOG;
    localparam int BLOCK_SIZE_LOG                = 4;

    localparam int WORD_SEL_W      = BLOCK_SIZE_LOG - 2;
    localparam int WORDS_PER_BLOCK = 1 << WORD_SEL_W;
    localparam int INDEX_W         = NUMBER_OF_BLOCKS_IN_CACHE_LOG;
    localparam int TAG_W           = ADDR_WIDTH - INDEX_W - BLOCK_SIZE_LOG;

    // One extra bit so the counter can sit at WORDS_PER_BLOCK for the completion cycle
    localparam int FILL_CNT_W = WORD_SEL_W + 1;
    localparam logic [FILL_CNT_W-1:0] FILL_CNT_DONE = FILL_CNT_W'(WORDS_PER_BLOCK);

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_W-1:0]     word_t;
    typedef logic [TAG_W-1:0]      tag_t;
    typedef logic [INDEX_W-1:0]    index_t;
    typedef logic [WORD_SEL_W-1:0] word_sel_t;

    typedef struct packed {
        tag_t      tag;
        index_t    index;
        word_sel_t word;
        logic [1:0] byte_off;
    } addr_fields_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOOKUP  = 2'd1,
        ST_REFILL  = 2'd2,
        ST_RESPOND = 2'd3
    } state_t;

    function automatic addr_fields_t split_addr(input addr_t a);
        return addr_fields_t'(a);
    endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Purpose: valid/tag/data storage for the direct-mapped load cache, with refill and snoop write ports.
// Latency: read port combinational (snoop data forwarded same cycle); writes land on the next edge.
// Backpressure: none; snoop always wins over refill data for the same word.
module dcache_line_array
    import dcache_load_port_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  index_t    rd_index,
    input  word_sel_t rd_word,
    output logic      rd_valid,
    output tag_t      rd_tag,
    output word_t     rd_data,
    input  logic      alloc_en,
    input  index_t    alloc_index,
    input  tag_t      alloc_tag,
    input  logic      fill_active,
    input  index_t    fill_index,
    input  logic      fill_we,
    input  word_sel_t fill_word,
    input  word_t     fill_data,
    input  logic      fill_done,
    input  logic      snoop_en,
    input  tag_t      snoop_tag,
    input  index_t    snoop_index,
    input  word_sel_t snoop_word,
    input  word_t     snoop_data
);

    logic [NUMBER_OF_BLOCKS_IN_CACHE-1:0] valid_q;
    logic [WORDS_PER_BLOCK-1:0]           snoop_mask_q;
    tag_t                                 tag_q  [NUMBER_OF_BLOCKS_IN_CACHE];
    word_t                                data_q [NUMBER_OF_BLOCKS_IN_CACHE][WORDS_PER_BLOCK];

    logic snoop_tag_hit;
    logic snoop_resident;
    logic snoop_refill;
    logic snoop_we;
    logic fill_keep;

    always_comb begin
        snoop_tag_hit  = (tag_q[snoop_index] == snoop_tag);
        snoop_resident = snoop_en && valid_q[snoop_index] && snoop_tag_hit;
        // Line under refill already carries its new tag but is not yet valid
        snoop_refill   = snoop_en && fill_active && (snoop_index == fill_index) && snoop_tag_hit;
        snoop_we       = snoop_resident || snoop_refill;
        fill_keep      = fill_we && !snoop_mask_q[fill_word]
                         && !(snoop_refill && (snoop_word == fill_word));
    end

    always_comb begin
        rd_valid = valid_q[rd_index];
        rd_tag   = tag_q[rd_index];
        rd_data  = data_q[rd_index][rd_word];
        if (snoop_we && (snoop_index == rd_index) && (snoop_word == rd_word)) begin
            rd_data = snoop_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q      <= '0;
            snoop_mask_q <= '0;
        end else if (alloc_en) begin
            valid_q[alloc_index] <= 1'b0;
            snoop_mask_q         <= '0;
        end else begin
            if (snoop_refill) begin
                snoop_mask_q[snoop_word] <= 1'b1;
            end
            if (fill_done) begin
                valid_q[fill_index] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_en) begin
            tag_q[alloc_index] <= alloc_tag;
        end
        if (snoop_we) begin
            data_q[snoop_index][snoop_word] <= snoop_data;
        end
        if (fill_keep) begin
            data_q[fill_index][fill_word] <= fill_data;
        end
    end

endmodule

// File: rtl/dcache_load_port.sv
// Purpose: load port of the data cache (lookup, word-serial refill, store snoop); DCACHE_LOAD_STATS_EN adds counters.
// Latency: hit -> readSuccess 2 cycles after the request edge; miss -> 2 cycles after the final mem_ack.
// Backpressure: one load in flight; readReady only in IDLE, requests elsewhere are dropped.
module dcache_load_port
    import dcache_load_port_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 readRequest,
    input  logic [ADDR_WIDTH-1:0]                readPtr,
    output logic                                 readReady,
    output logic [DATA_W-1:0]                    readValue,
    output logic                                 readSuccess,
    output logic [NUMBER_OF_BLOCKS_IN_CACHE-1:0] busy,
    output logic                                 mem_req,
    output logic [ADDR_WIDTH-1:0]                mem_addr,
    input  logic                                 mem_ack,
    input  logic [DATA_W-1:0]                    mem_data,
    input  logic                                 write_en,
    input  logic [ADDR_WIDTH-1:0]                write_addr,
    input  logic [DATA_W-1:0]                    write_data
`ifdef DCACHE_LOAD_STATS_EN
    ,
    output logic [31:0]                          hitCount,
    output logic [31:0]                          missCount
`endif
);

    state_t                state_q, state_d;
    tag_t                  req_tag_q;
    index_t                req_index_q;
    word_sel_t             req_word_q;
    logic [FILL_CNT_W-1:0] fill_cnt_q, fill_cnt_d;

    addr_fields_t rd_f;
    addr_fields_t wr_f;
    logic         unused_byte_bits;

    logic  capture;
    logic  lookup_hit;
    logic  alloc_en;
    logic  fill_we;
    logic  fill_done;
    logic  arr_valid;
    tag_t  arr_tag;
    word_t arr_data;

    assign rd_f             = split_addr(readPtr);
    assign wr_f             = split_addr(write_addr);
    assign unused_byte_bits = ^{rd_f.byte_off, wr_f.byte_off};
    assign lookup_hit       = arr_valid && (arr_tag == req_tag_q);

    dcache_line_array u_lines (
        .clk         (clk),
        .reset       (reset),
        .rd_index    (req_index_q),
        .rd_word     (req_word_q),
        .rd_valid    (arr_valid),
        .rd_tag      (arr_tag),
        .rd_data     (arr_data),
        .alloc_en    (alloc_en),
        .alloc_index (req_index_q),
        .alloc_tag   (req_tag_q),
        .fill_active (state_q == ST_REFILL),
        .fill_index  (req_index_q),
        .fill_we     (fill_we),
        .fill_word   (fill_cnt_q[WORD_SEL_W-1:0]),
        .fill_data   (mem_data),
        .fill_done   (fill_done),
        .snoop_en    (write_en),
        .snoop_tag   (wr_f.tag),
        .snoop_index (wr_f.index),
        .snoop_word  (wr_f.word),
        .snoop_data  (write_data)
    );

    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        capture     = 1'b0;
        readReady   = 1'b0;
        readSuccess = 1'b0;
        readValue   = '0;
        mem_req     = 1'b0;
        mem_addr    = '0;
        busy        = '0;
        alloc_en    = 1'b0;
        fill_we     = 1'b0;
        fill_done   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                readReady = reset;
                if (readRequest) begin
                    capture = 1'b1;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (lookup_hit) begin
                    state_d = ST_RESPOND;
                end else begin
                    alloc_en   = 1'b1;
                    fill_cnt_d = '0;
                    state_d    = ST_REFILL;
                end
            end
            ST_REFILL: begin
                busy[req_index_q] = 1'b1;
                // After the last word the request drops for one cycle while the line is marked valid
                if (fill_cnt_q != FILL_CNT_DONE) begin
                    mem_req  = 1'b1;
                    mem_addr = {req_tag_q, req_index_q, fill_cnt_q[WORD_SEL_W-1:0], 2'b00};
                    if (mem_ack) begin
                        fill_we    = 1'b1;
                        fill_cnt_d = fill_cnt_q + FILL_CNT_W'(1);
                    end
                end else begin
                    fill_done = 1'b1;
                    state_d   = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                readSuccess = 1'b1;
                readValue   = arr_data;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            fill_cnt_q  <= '0;
            req_tag_q   <= '0;
            req_index_q <= '0;
            req_word_q  <= '0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            if (capture) begin
                req_tag_q   <= rd_f.tag;
                req_index_q <= rd_f.index;
                req_word_q  <= rd_f.word;
            end
        end
    end

`ifdef DCACHE_LOAD_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hitCount  <= '0;
            missCount <= '0;
        end else if (state_q == ST_LOOKUP) begin
            if (lookup_hit) begin
                hitCount <= hitCount + 32'd1;
            end else begin
                missCount <= missCount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_load_port.sv
// Scoreboard bench for dcache_load_port: word-serial memory model with programmable ack stall.
// Expected load data is queued at request time and compared when readSuccess is observed.
module tb_dcache_load_port;
    import dcache_load_port_pkg::*;

    logic        clk;
    logic        reset;
    logic        readRequest;
    logic [31:0] readPtr;
    logic        readReady;
    logic [31:0] readValue;
    logic        readSuccess;
    logic [3:0]  busy;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic        write_en;
    logic [31:0] write_addr;
    logic [31:0] write_data;
`ifdef DCACHE_LOAD_STATS_EN
    logic [31:0] hitCount;
    logic [31:0] missCount;
`endif

    dcache_load_port dut (
        .clk         (clk),
        .reset       (reset),
        .readRequest (readRequest),
        .readPtr     (readPtr),
        .readReady   (readReady),
        .readValue   (readValue),
        .readSuccess (readSuccess),
        .busy        (busy),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data),
        .write_en    (write_en),
        .write_addr  (write_addr),
        .write_data  (write_data)
`ifdef DCACHE_LOAD_STATS_EN
        ,
        .hitCount    (hitCount),
        .missCount   (missCount)
`endif
    );

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int ack_delay = 0;
    int wait_cnt  = 0;
    logic late_ack = 1'b0;
    int last_ack_cyc  = 0;
    int memreq_cycles = 0;
    int req_cyc = 0;

    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    int          obs_cyc_q[$];
    logic [31:0] ack_addr_q[$];
    logic [3:0]  ack_busy_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:4] == 28'h10) return 32'hA0 + 32'(a[3:2]);
        return {a[15:0], 16'hC0DE};
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required earlier finish", $time);
        $fatal(1);
    end

    // Memory model and output monitor, both on the falling edge
    initial begin
        mem_ack  = 1'b0;
        mem_data = '0;
        forever begin
            @(negedge clk);
            if (readSuccess) begin
                obs_q.push_back(readValue);
                obs_cyc_q.push_back(cyc);
            end
            if (mem_req) memreq_cycles++;
            if (mem_req && reset) begin
                if (wait_cnt >= ack_delay) begin
                    mem_ack  = 1'b1;
                    mem_data = mem_word(mem_addr);
                    wait_cnt = 0;
                    ack_addr_q.push_back(mem_addr);
                    ack_busy_q.push_back(busy);
                    last_ack_cyc = cyc;
                end else begin
                    mem_ack  = 1'b0;
                    mem_data = '0;
                    wait_cnt++;
                end
            end else begin
                mem_ack  = late_ack;
                mem_data = 32'hBAD0_BAD0;
                wait_cnt = 0;
            end
        end
    end

    task automatic issue_read(input logic [31:0] addr, input logic [31:0] exp);
        int n = 0;
        @(posedge clk); #1;
        while (!readReady && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!readReady) begin
            fails++;
            $display("FAIL issue_ready addr=%h readReady=%b required 1", addr, readReady);
        end else begin
            readRequest = 1'b1;
            readPtr     = addr;
            exp_q.push_back(exp);
            req_cyc = cyc;
            @(posedge clk); #1;
            readRequest = 1'b0;
        end
    endtask

    task automatic wait_resp(input string name, output int succ_cyc);
        int n = 0;
        logic [31:0] v;
        logic [31:0] e;
        succ_cyc = -1;
        while (obs_q.size() == 0 && n < 600) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (obs_q.size() == 0) begin
            fails++;
            $display("FAIL %s timeout: no readSuccess, required one", name);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end else if (exp_q.size() == 0) begin
            fails++;
            v = obs_q.pop_front();
            void'(obs_cyc_q.pop_front());
            $display("FAIL %s unexpected readSuccess value=%h, required none", name, v);
        end else begin
            v = obs_q.pop_front();
            succ_cyc = obs_cyc_q.pop_front();
            e = exp_q.pop_front();
            if (v !== e) begin
                fails++;
                $display("FAIL %s readValue=%h required %h", name, v, e);
            end
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        write_en = 1'b1; write_addr = addr; write_data = data;
        @(posedge clk); #1;
        write_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; readRequest = 1'b0; readPtr = '0;
        write_en = 1'b0; write_addr = '0; write_data = '0;
        repeat (2) @(posedge clk); #1;
        checks++; if (readReady !== 1'b0)   begin fails++; $display("FAIL rst_ready got=%b required 0", readReady); end
        checks++; if (readSuccess !== 1'b0) begin fails++; $display("FAIL rst_success got=%b required 0", readSuccess); end
        checks++; if (readValue !== 32'h0)  begin fails++; $display("FAIL rst_value got=%h required 0", readValue); end
        checks++; if (mem_req !== 1'b0)     begin fails++; $display("FAIL rst_mem_req got=%b required 0", mem_req); end
        checks++; if (mem_addr !== 32'h0)   begin fails++; $display("FAIL rst_mem_addr got=%h required 0", mem_addr); end
        checks++; if (busy !== 4'h0)        begin fails++; $display("FAIL rst_busy got=%b required 0", busy); end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (readReady !== 1'b1)   begin fails++; $display("FAIL rst_release_ready got=%b required 1", readReady); end
    endtask

    task automatic test_cold_miss();
        int sc;
        ack_addr_q.delete(); ack_busy_q.delete();
        issue_read(32'h100, 32'hA0);
        wait_resp("cold_miss", sc);
        checks++;
        if (ack_addr_q.size() != 4) begin
            fails++; $display("FAIL cold_ack_count got=%0d required 4", ack_addr_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (ack_addr_q[i] !== 32'h100 + 32'(4 * i)) begin
                    fails++; $display("FAIL cold_mem_addr[%0d] got=%h required %h", i, ack_addr_q[i], 32'h100 + 32'(4 * i));
                end
                checks++;
                if (ack_busy_q[i] !== 4'b0001) begin
                    fails++; $display("FAIL cold_busy[%0d] got=%b required 0001", i, ack_busy_q[i]);
                end
            end
        end
        checks++;
        if (sc - last_ack_cyc != 2) begin
            fails++; $display("FAIL cold_latency got=%0d required 2", sc - last_ack_cyc);
        end
    endtask

    task automatic test_hit();
        int sc;
        int mr = memreq_cycles;
        issue_read(32'h108, 32'hA2);
        wait_resp("hit", sc);
        checks++; if (sc - req_cyc != 2) begin fails++; $display("FAIL hit_latency got=%0d required 2", sc - req_cyc); end
        issue_read(32'h10B, 32'hA2);
        wait_resp("hit_byte_offset", sc);
        checks++; if (memreq_cycles != mr) begin fails++; $display("FAIL hit_mem_traffic got=%0d required %0d", memreq_cycles, mr); end
    endtask

    task automatic test_conflict();
        int sc;
        ack_addr_q.delete(); ack_busy_q.delete();
        issue_read(32'h140, mem_word(32'h140));
        wait_resp("conflict_fill", sc);
        checks++; if (ack_addr_q.size() != 4) begin fails++; $display("FAIL conflict_ack_count got=%0d required 4", ack_addr_q.size()); end
        issue_read(32'h100, 32'hA0);
        wait_resp("conflict_reread", sc);
        checks++; if (ack_addr_q.size() != 8) begin fails++; $display("FAIL conflict_remiss_count got=%0d required 8", ack_addr_q.size()); end
`ifdef DCACHE_LOAD_STATS_EN
        checks++; if (missCount !== 32'd3) begin fails++; $display("FAIL stats_miss got=%0d required 3", missCount); end
        checks++; if (hitCount !== 32'd2)  begin fails++; $display("FAIL stats_hit got=%0d required 2", hitCount); end
`endif
    endtask

    task automatic test_snoop_hit();
        int sc;
        int mr = memreq_cycles;
        do_write(32'h104, 32'hDEAD);
        issue_read(32'h104, 32'hDEAD);
        wait_resp("snoop_hit", sc);
        do_write(32'h500, 32'h1111);
        issue_read(32'h100, 32'hA0);
        wait_resp("snoop_nonresident", sc);
        checks++; if (memreq_cycles != mr) begin fails++; $display("FAIL snoop_mem_traffic got=%0d required %0d", memreq_cycles, mr); end
    endtask

    task automatic test_merge();
        int sc;
        int n = 0;
        int mr;
        ack_delay = 3;
        ack_addr_q.delete(); ack_busy_q.delete();
        issue_read(32'h200, mem_word(32'h200));
        while (!(mem_req && mem_addr == 32'h204) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checks++; if (mem_addr !== 32'h204) begin fails++; $display("FAIL merge_reach_word1 mem_addr=%h required 00000204", mem_addr); end
        do_write(32'h208, 32'h1234);
        wait_resp("merge_fill", sc);
        checks++; if (ack_addr_q.size() != 4) begin fails++; $display("FAIL merge_ack_count got=%0d required 4", ack_addr_q.size()); end
        checks++; if (sc - last_ack_cyc != 2) begin fails++; $display("FAIL merge_latency got=%0d required 2", sc - last_ack_cyc); end
        ack_delay = 0;
        mr = memreq_cycles;
        issue_read(32'h208, 32'h1234);
        wait_resp("merge_word", sc);
        issue_read(32'h204, mem_word(32'h204));
        wait_resp("merge_other_word", sc);
        checks++; if (memreq_cycles != mr) begin fails++; $display("FAIL merge_mem_traffic got=%0d required %0d", memreq_cycles, mr); end
    endtask

    task automatic test_final_ack_snoop();
        int sc;
        int n = 0;
        ack_addr_q.delete(); ack_busy_q.delete();
        issue_read(32'h310, mem_word(32'h310));
        while (!(mem_req && mem_addr == 32'h31C) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        write_en = 1'b1; write_addr = 32'h31C; write_data = 32'h5555;
        @(posedge clk); #1;
        write_en = 1'b0;
        wait_resp("final_ack_fill", sc);
        checks++;
        if (ack_busy_q.size() == 0 || ack_busy_q[0] !== 4'b0010) begin
            fails++; $display("FAIL final_busy got=%b required 0010", (ack_busy_q.size() == 0) ? 4'hx : ack_busy_q[0]);
        end
        issue_read(32'h31C, 32'h5555);
        wait_resp("final_ack_snoop_wins", sc);
    endtask

    task automatic test_back_to_back();
        int sc1;
        int sc2;
        issue_read(32'h310, mem_word(32'h310));
        readRequest = 1'b1; readPtr = 32'h314;
        @(posedge clk); #1;
        readPtr = 32'h318;
        @(posedge clk); #1;
        readRequest = 1'b0;
        wait_resp("ignored_base", sc1);
        repeat (5) @(posedge clk); #1;
        checks++; if (obs_q.size() != 0) begin fails++; $display("FAIL ignored_requests got=%0d extra responses required 0", obs_q.size()); end
        issue_read(32'h314, mem_word(32'h314));
        wait_resp("b2b_first", sc1);
        issue_read(32'h318, mem_word(32'h318));
        checks++; if (req_cyc != sc1 + 1) begin fails++; $display("FAIL b2b_accept got=%0d required %0d", req_cyc, sc1 + 1); end
        wait_resp("b2b_second", sc2);
        checks++; if (sc2 - req_cyc != 2) begin fails++; $display("FAIL b2b_latency got=%0d required 2", sc2 - req_cyc); end
    endtask

    task automatic test_snoop_respond();
        int sc;
        issue_read(32'h314, 32'h7777);
        @(posedge clk); #1;
        write_en = 1'b1; write_addr = 32'h314; write_data = 32'h7777;
        @(posedge clk); #1;
        write_en = 1'b0;
        wait_resp("snoop_in_respond", sc);
        issue_read(32'h314, 32'h7777);
        wait_resp("snoop_in_respond_kept", sc);
    endtask

    task automatic test_reset_mid_refill();
        int sc;
        int n = 0;
        ack_addr_q.delete(); ack_busy_q.delete();
        issue_read(32'h400, mem_word(32'h400));
        while (ack_addr_q.size() < 2 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0)   begin fails++; $display("FAIL midrst_mem_req got=%b required 0", mem_req); end
        checks++; if (busy !== 4'h0)      begin fails++; $display("FAIL midrst_busy got=%b required 0", busy); end
        checks++; if (readReady !== 1'b0) begin fails++; $display("FAIL midrst_ready got=%b required 0", readReady); end
        exp_q.delete();
        repeat (3) @(posedge clk); #1;
        reset = 1'b1;
        late_ack = 1'b1;
        @(posedge clk); #1;
        late_ack = 1'b0;
        repeat (5) @(posedge clk); #1;
        checks++; if (obs_q.size() != 0)  begin fails++; $display("FAIL midrst_success got=%0d responses required 0", obs_q.size()); end
        checks++; if (readReady !== 1'b1) begin fails++; $display("FAIL midrst_idle got=%b required 1", readReady); end
        checks++; if (mem_req !== 1'b0)   begin fails++; $display("FAIL midrst_late_ack mem_req=%b required 0", mem_req); end
`ifdef DCACHE_LOAD_STATS_EN
        checks++; if (missCount !== 32'd0) begin fails++; $display("FAIL stats_reset_miss got=%0d required 0", missCount); end
`endif
        ack_addr_q.delete();
        issue_read(32'h400, mem_word(32'h400));
        wait_resp("midrst_reread", sc);
        checks++; if (ack_addr_q.size() != 4) begin fails++; $display("FAIL midrst_remiss got=%0d acks required 4", ack_addr_q.size()); end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_snoop_hit();
        test_merge();
        test_final_ack_snoop();
        test_back_to_back();
        test_snoop_respond();
        test_reset_mid_refill();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
